// File: rtl/seq_stage_ctrl_pkg.sv
// Shared constants for the sequential stage controller: icodes, status codes,
// FSM state encoding and the icode classification payload.
package seq_stage_ctrl_pkg;

   localparam int unsigned ICODE_W = 4;
   localparam int unsigned STAT_W  = 3;
   localparam int unsigned STAGE_W = 6;
   localparam int unsigned PERF_W  = 32;

   localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
   localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
   localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
   localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
   localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
   localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
   localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
   localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
   localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
   localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
   localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
   localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

   localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
   localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
   localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
   localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_PCUPD     = 3'd6,
      ST_HALT      = 3'd7
   } state_t;

   typedef struct packed {
      logic is_mem;
      logic is_wb;
   } icode_class_t;

   // One-hot stage enable for a state; idle and halt enable nothing.
   function automatic logic [STAGE_W-1:0] stage_onehot(input state_t s);
      logic [STAGE_W-1:0] oh;
      oh = '0;
      case (s)
         ST_FETCH:     oh = 6'b00_0001;
         ST_DECODE:    oh = 6'b00_0010;
         ST_EXECUTE:   oh = 6'b00_0100;
         ST_MEMORY:    oh = 6'b00_1000;
         ST_WRITEBACK: oh = 6'b01_0000;
         ST_PCUPD:     oh = 6'b10_0000;
         default:      oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/seq_icode_class.sv
// Combinational icode classifier: data-memory access and register writeback.
module seq_icode_class
   import seq_stage_ctrl_pkg::*;
(
   input  logic [ICODE_W-1:0] icode,
   output icode_class_t       cls_c
);

   always_comb begin
      cls_c = '0;
      case (icode)
         I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: cls_c.is_mem = 1'b1;
         default:                                            cls_c.is_mem = 1'b0;
      endcase
      case (icode)
         I_RRMOVQ, I_IRMOVQ, I_MRMOVQ, I_OPQ,
         I_CALL, I_RET, I_PUSHQ, I_POPQ:                     cls_c.is_wb = 1'b1;
         default:                                            cls_c.is_wb = 1'b0;
      endcase
   end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle stage sequencer for a Y86-style core.
// Optional performance counters enabled by defining SEQ_PERF_CNT_EN.
module seq_stage_ctrl
   import seq_stage_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ICODE_W-1:0] icode,
   input  logic               instr_valid,
   input  logic               imem_error,
   input  logic               mem_ack,
   input  logic               dmem_error,
   output logic [STAGE_W-1:0] stage_en,
   output logic               mem_req,
   output logic               wb_en,
   output logic               pc_load,
   output logic [STAT_W-1:0]  stat,
   output logic               halted
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [PERF_W-1:0]  cycle_cnt,
   output logic [PERF_W-1:0]  instr_cnt
`endif
);

   localparam int unsigned TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t              state, state_n;
   logic [STAT_W-1:0]   stat_n;
   logic [ICODE_W-1:0]  icode_q, icode_n;
   logic [TMO_W-1:0]    tmo, tmo_n;
   icode_class_t        cls;
   logic [STAGE_W-1:0]  stage_en_n;
   logic                mem_req_n, wb_en_n, pc_load_n, halted_n;

   // Latched icode as it will be next cycle; only a clean fetch replaces it.
   assign icode_n = (state == ST_FETCH && !imem_error && instr_valid) ? icode : icode_q;

   seq_icode_class u_class (
      .icode (icode_n),
      .cls_c (cls)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         stat     <= STAT_AOK;
         icode_q  <= I_HALT;
         tmo      <= '0;
         stage_en <= '0;
         mem_req  <= 1'b0;
         wb_en    <= 1'b0;
         pc_load  <= 1'b0;
         halted   <= 1'b0;
      end else begin
         state    <= state_n;
         stat     <= stat_n;
         icode_q  <= icode_n;
         tmo      <= tmo_n;
         stage_en <= stage_en_n;
         mem_req  <= mem_req_n;
         wb_en    <= wb_en_n;
         pc_load  <= pc_load_n;
         halted   <= halted_n;
      end
   end

   always_comb begin
      state_n = state;
      stat_n  = stat;
      tmo_n   = '0;
      case (state)
         ST_IDLE:    if (start) state_n = ST_FETCH;
         ST_FETCH: begin
            if (imem_error) begin
               state_n = ST_HALT;
               stat_n  = STAT_ADR;
            end else if (!instr_valid) begin
               state_n = ST_HALT;
               stat_n  = STAT_INS;
            end else begin
               state_n = ST_DECODE;
            end
         end
         ST_DECODE:  state_n = ST_EXECUTE;
         ST_EXECUTE: state_n = ST_MEMORY;
         ST_MEMORY: begin
            // tmo counts completed waiting cycles since MEMORY entry.
            if (!cls.is_mem) begin
               state_n = ST_WRITEBACK;
            end else if (mem_ack) begin
               if (dmem_error) begin
                  state_n = ST_HALT;
                  stat_n  = STAT_ADR;
               end else begin
                  state_n = ST_WRITEBACK;
               end
            end else if (tmo == TMO_W'(MEM_TIMEOUT - 1)) begin
               state_n = ST_HALT;
               stat_n  = STAT_ADR;
            end else begin
               tmo_n = tmo + TMO_W'(1);
            end
         end
         ST_WRITEBACK: state_n = ST_PCUPD;
         ST_PCUPD: begin
            if (icode_q == I_HALT) begin
               state_n = ST_HALT;
               stat_n  = STAT_HLT;
            end else begin
               state_n = ST_FETCH;
               stat_n  = STAT_AOK;
            end
         end
         ST_HALT:    state_n = ST_HALT;
         default:    state_n = ST_IDLE;
      endcase

      // Outputs are registered, so they decode the state being entered.
      stage_en_n = stage_onehot(state_n);
      mem_req_n  = (state_n == ST_MEMORY) && cls.is_mem;
      wb_en_n    = (state_n == ST_WRITEBACK) && cls.is_wb;
      pc_load_n  = (state_n == ST_PCUPD);
      halted_n   = (state_n == ST_HALT);
   end

`ifdef SEQ_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (state != ST_IDLE && state != ST_HALT) cycle_cnt <= cycle_cnt + PERF_W'(1);
         if (pc_load)                              instr_cnt <= instr_cnt + PERF_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed self-checking bench for seq_stage_ctrl.
module tb_seq_stage_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] icode;
   logic       instr_valid;
   logic       imem_error;
   logic       mem_ack;
   logic       dmem_error;
   logic [5:0] stage_en;
   logic       mem_req;
   logic       wb_en;
   logic       pc_load;
   logic [2:0] stat;
   logic       halted;
`ifdef SEQ_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;
`endif

   int checks = 0;
   int errors = 0;

   seq_stage_ctrl #(.MEM_TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .icode       (icode),
      .instr_valid (instr_valid),
      .imem_error  (imem_error),
      .mem_ack     (mem_ack),
      .dmem_error  (dmem_error),
      .stage_en    (stage_en),
      .mem_req     (mem_req),
      .wb_en       (wb_en),
      .pc_load     (pc_load),
      .stat        (stat),
      .halted      (halted)
`ifdef SEQ_PERF_CNT_EN
      ,
      .cycle_cnt   (cycle_cnt),
      .instr_cnt   (instr_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      icode = 4'h1;
      instr_valid = 1'b1;
      imem_error = 1'b0;
      mem_ack = 1'b0;
      dmem_error = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start(input logic [3:0] ic);
      icode = ic;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (stage_en !== 6'h00 || mem_req !== 1'b0 || wb_en !== 1'b0 ||
          pc_load !== 1'b0 || stat !== 3'd1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset: stage_en=%h mem_req=%b wb_en=%b pc_load=%b stat=%0d halted=%b, required 00 0 0 0 1 0",
                  stage_en, mem_req, wb_en, pc_load, stat, halted);
      end
      // No start: stays idle.
      tick();
      tick();
      checks++;
      if (stage_en !== 6'h00 || halted !== 1'b0) begin
         errors++;
         $display("FAIL idle_hold: stage_en=%h halted=%b, required 00 0", stage_en, halted);
      end
   endtask

   // icode 6 with mem_ack/dmem_error held high: memory handshake must be ignored.
   task automatic test_nonmem();
      logic [5:0] exp_se [7];
      logic       exp_wb [7];
      logic       exp_pc [7];
      exp_se = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
      exp_wb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_pc = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_reset();
      mem_ack = 1'b1;
      dmem_error = 1'b1;
      do_start(4'h6);
      for (int i = 0; i < 7; i++) begin
         if (i > 0) tick();
         checks++;
         if (stage_en !== exp_se[i] || wb_en !== exp_wb[i] || pc_load !== exp_pc[i] ||
             mem_req !== 1'b0 || stat !== 3'd1) begin
            errors++;
            $display("FAIL nonmem cycle %0d: stage_en=%h wb_en=%b pc_load=%b mem_req=%b stat=%0d, required %h %b %b 0 1",
                     i, stage_en, wb_en, pc_load, mem_req, stat, exp_se[i], exp_wb[i], exp_pc[i]);
         end
      end
   endtask

   // icode 5, ack on the third MEMORY cycle.
   task automatic test_mem_ack();
      logic [5:0] exp_se [9];
      logic       exp_mr [9];
      int         n_mr, n_wb, n_pc;
      exp_se = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h08, 6'h08, 6'h10, 6'h20, 6'h01};
      exp_mr = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      n_mr = 0; n_wb = 0; n_pc = 0;
      do_reset();
      do_start(4'h5);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) tick();
         mem_ack = (i == 5);
         if (mem_req === 1'b1) n_mr++;
         if (wb_en === 1'b1) n_wb++;
         if (pc_load === 1'b1) n_pc++;
         checks++;
         if (stage_en !== exp_se[i] || mem_req !== exp_mr[i]) begin
            errors++;
            $display("FAIL mem_ack cycle %0d: stage_en=%h mem_req=%b, required %h %b",
                     i, stage_en, mem_req, exp_se[i], exp_mr[i]);
         end
      end
      mem_ack = 1'b0;
      checks++;
      if (n_mr != 3 || n_wb != 1 || n_pc != 1 || stat !== 3'd1) begin
         errors++;
         $display("FAIL mem_ack totals: mem_req=%0d wb_en=%0d pc_load=%0d stat=%0d, required 3 1 1 1",
                  n_mr, n_wb, n_pc, stat);
      end
   endtask

   // icode 4, no ack: 15 MEMORY cycles then address-error halt.
   task automatic test_timeout();
      int n_pc, n_mem;
      n_pc = 0; n_mem = 0;
      do_reset();
      do_start(4'h4);
      tick();
      tick();
      for (int i = 0; i < 15; i++) begin
         tick();
         if (pc_load === 1'b1) n_pc++;
         if (stage_en === 6'h08 && mem_req === 1'b1) n_mem++;
      end
      checks++;
      if (n_mem != 15) begin
         errors++;
         $display("FAIL timeout mem cycles: got %0d, required 15", n_mem);
      end
      tick();
      if (pc_load === 1'b1) n_pc++;
      checks++;
      if (halted !== 1'b1 || stat !== 3'd3 || mem_req !== 1'b0 || stage_en !== 6'h00 || n_pc != 0) begin
         errors++;
         $display("FAIL timeout halt: halted=%b stat=%0d mem_req=%b stage_en=%h pc_loads=%0d, required 1 3 0 00 0",
                  halted, stat, mem_req, stage_en, n_pc);
      end
   endtask

   // icode 9, ack with dmem_error on first MEMORY cycle.
   task automatic test_dmem_error();
      int n_wb, n_pc;
      n_wb = 0; n_pc = 0;
      do_reset();
      do_start(4'h9);
      tick();
      tick();
      tick();
      mem_ack = 1'b1;
      dmem_error = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         mem_ack = 1'b0;
         dmem_error = 1'b0;
         if (wb_en === 1'b1) n_wb++;
         if (pc_load === 1'b1) n_pc++;
      end
      checks++;
      if (halted !== 1'b1 || stat !== 3'd3 || n_wb != 0 || n_pc != 0) begin
         errors++;
         $display("FAIL dmem_error: halted=%b stat=%0d wb=%0d pc=%0d, required 1 3 0 0",
                  halted, stat, n_wb, n_pc);
      end
   endtask

   // icode 0 runs to PCUPD then halts with HLT; start is ignored afterwards.
   task automatic test_halt();
      int n_wb;
      n_wb = 0;
      do_reset();
      do_start(4'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (wb_en === 1'b1) n_wb++;
      end
      checks++;
      if (pc_load !== 1'b1 || stage_en !== 6'h20 || halted !== 1'b0 || n_wb != 0) begin
         errors++;
         $display("FAIL halt pcupd: pc_load=%b stage_en=%h halted=%b wb=%0d, required 1 20 0 0",
                  pc_load, stage_en, halted, n_wb);
      end
      tick();
      checks++;
      if (halted !== 1'b1 || stat !== 3'd2 || stage_en !== 6'h00 || pc_load !== 1'b0) begin
         errors++;
         $display("FAIL halt state: halted=%b stat=%0d stage_en=%h pc_load=%b, required 1 2 00 0",
                  halted, stat, stage_en, pc_load);
      end
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (halted !== 1'b1 || stat !== 3'd2 || stage_en !== 6'h00) begin
         errors++;
         $display("FAIL halt sticky: halted=%b stat=%0d stage_en=%h, required 1 2 00",
                  halted, stat, stage_en);
      end
   endtask

   task automatic test_fetch_errors();
      do_reset();
      do_start(4'h6);
      instr_valid = 1'b0;
      tick();
      checks++;
      if (halted !== 1'b1 || stat !== 3'd4 || stage_en !== 6'h00) begin
         errors++;
         $display("FAIL fetch_ins: halted=%b stat=%0d stage_en=%h, required 1 4 00",
                  halted, stat, stage_en);
      end
      do_reset();
      do_start(4'h6);
      instr_valid = 1'b0;
      imem_error = 1'b1;
      tick();
      checks++;
      if (halted !== 1'b1 || stat !== 3'd3) begin
         errors++;
         $display("FAIL fetch_adr: halted=%b stat=%0d, required 1 3", halted, stat);
      end
      imem_error = 1'b0;
      instr_valid = 1'b1;
   endtask

   // icode 6 followed by icode 0: new icode latched on the second fetch.
   task automatic test_back_to_back();
      do_reset();
      do_start(4'h6);
      for (int i = 0; i < 6; i++) tick();
      icode = 4'h0;
      checks++;
      if (stage_en !== 6'h01 || stat !== 3'd1) begin
         errors++;
         $display("FAIL b2b refetch: stage_en=%h stat=%0d, required 01 1", stage_en, stat);
      end
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (wb_en !== 1'b0 || stage_en !== 6'h10) begin
         errors++;
         $display("FAIL b2b wb: wb_en=%b stage_en=%h, required 0 10", wb_en, stage_en);
      end
      tick();
      tick();
      checks++;
      if (halted !== 1'b1 || stat !== 3'd2) begin
         errors++;
         $display("FAIL b2b halt: halted=%b stat=%0d, required 1 2", halted, stat);
      end
   endtask

   task automatic test_rst_mid_mem();
      do_reset();
      do_start(4'h5);
      tick();
      tick();
      tick();
      checks++;
      if (mem_req !== 1'b1 || stage_en !== 6'h08) begin
         errors++;
         $display("FAIL rst_mid pre: mem_req=%b stage_en=%h, required 1 08", mem_req, stage_en);
      end
`ifdef SEQ_PERF_CNT_EN
      checks++;
      if (cycle_cnt !== 32'd3 || instr_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf pre: cycle_cnt=%0d instr_cnt=%0d, required 3 0", cycle_cnt, instr_cnt);
      end
`endif
      rst = 1'b1;
      mem_ack = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      mem_ack = 1'b0;
      start = 1'b0;
      checks++;
      if (mem_req !== 1'b0 || stage_en !== 6'h00 || stat !== 3'd1 || halted !== 1'b0 ||
          wb_en !== 1'b0 || pc_load !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid post: mem_req=%b stage_en=%h stat=%0d halted=%b wb=%b pc=%b, required 0 00 1 0 0 0",
                  mem_req, stage_en, stat, halted, wb_en, pc_load);
      end
`ifdef SEQ_PERF_CNT_EN
      checks++;
      if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
         errors++;
         $display("FAIL perf post: cycle_cnt=%0d instr_cnt=%0d, required 0 0", cycle_cnt, instr_cnt);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_nonmem();
      test_mem_ack();
      test_timeout();
      test_dmem_error();
      test_halt();
      test_fetch_errors();
      test_back_to_back();
      test_rst_mid_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_stage_ctrl.md
SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: max cycles waiting for mem_ack before an address error is declared.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  pulse: leave IDLE and begin fetching.
REQ-005 icode  input  4  instruction code from fetch, sampled at end of FETCH.
REQ-006 instr_valid  input  1  fetch reports legal icode/ifun, sampled at end of FETCH.
REQ-007 imem_error  input  1  fetch address out of range, sampled at end of FETCH.
REQ-008 mem_ack  input  1  data memory completes the current access.
REQ-009 dmem_error  input  1  data memory address error, qualified by mem_ack.
REQ-010 stage_en  output  6  one-hot enable: bit0 fetch, bit1 decode, bit2 execute, bit3 memory, bit4 writeback, bit5 pc update.
REQ-011 mem_req  output  1  data memory access request.
REQ-012 wb_en  output  1  register-file write strobe (dstE/dstM ports).
REQ-013 pc_load  output  1  load next PC into PC register.
REQ-014 stat  output  3  processor status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-015 halted  output  1  high while in HALT state.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT.
REQ-017 IDLE -> FETCH on start; otherwise stay in IDLE.
REQ-018 FETCH -> HALT with stat=3 if imem_error; else -> HALT with stat=4 if !instr_valid; else -> DECODE, latching icode.
REQ-019 DECODE -> EXECUTE -> MEMORY, one cycle each; stage_en equals the current state's one-hot bit, zero in IDLE/HALT.
REQ-020 Memory-class icodes (4,5,8,9,A,B): mem_req high from MEMORY entry until the cycle mem_ack is high inclusive; exit MEMORY the cycle after mem_ack.
REQ-021 Non-memory icodes: MEMORY lasts exactly one cycle, mem_req stays low, mem_ack ignored.
REQ-022 mem_ack with dmem_error -> HALT with stat=3; no writeback, no pc_load.
REQ-023 No mem_ack within MEM_TIMEOUT cycles of MEMORY entry -> HALT with stat=3; mem_req deasserts on the HALT transition.
REQ-024 WRITEBACK lasts one cycle; wb_en high in it only for icodes 2,3,5,6,8,9,A,B.
REQ-025 PCUPD lasts one cycle with pc_load high; then -> HALT with stat=2 if latched icode=0, else -> FETCH with stat=1.
REQ-026 Non-memory instruction latency: 6 cycles FETCH to PCUPD inclusive; memory instruction: 5 + k, k = MEMORY cycles.
REQ-027 HALT is sticky; only rst leaves it; start ignored in HALT and in all non-IDLE states.
REQ-028 wb_en and pc_load SHALL never assert in the same cycle or after any error.

Reset
REQ-029 rst SHALL override all inputs including a mid-memory access: state=IDLE, stat=1, stage_en=0, mem_req=0, wb_en=0, pc_load=0, halted=0, timeout counter=0, latched icode=0.
REQ-030 First state transition occurs on the first edge after rst deasserts.

Configuration
REQ-031 With SEQ_PERF_CNT_EN defined: outputs cycle_cnt[31:0] (increments every non-IDLE, non-HALT cycle) and instr_cnt[31:0] (increments on each pc_load), both wrap at 2^32, both cleared by rst.
REQ-032 Without SEQ_PERF_CNT_EN: those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-033 Shared package SHALL hold icode constants (HALT..POPQ), stat codes AOK/HLT/ADR/INS, and the FSM state encoding.
REQ-034 One sub-module seq_icode_class: combinational icode -> {is_mem, is_wb}, reused by decode/writeback logic.

Verification
REQ-035 rst, start, icode=6 valid -> stage_en 01,02,04,08,10,20 over 6 cycles, wb_en in cycle 5, pc_load in cycle 6, back in FETCH.
REQ-036 icode=5, mem_ack on 3rd MEMORY cycle -> mem_req high 3 cycles, wb_en once, pc_load once, stat=1.
REQ-037 icode=4, mem_ack never -> after 15 MEMORY cycles HALT, stat=3, halted=1, no pc_load.
REQ-038 icode=0 -> PCUPD then HALT, stat=2; start pulse afterwards -> stays HALT.
REQ-039 instr_valid=0 at FETCH -> HALT stat=4; imem_error=1 with instr_valid=0 -> stat=3 (priority).
REQ-040 rst asserted mid-MEMORY with mem_req high -> next cycle IDLE, mem_req=0, stat=1; with SEQ_PERF_CNT_EN both counters read 0.
